// File: rtl/dmem_pkg.sv
// dmem_pkg: size encodings, FSM states and lane constants shared by the data-memory block
package dmem_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam int LANE_W = 8;
  localparam int LANES = 4;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
  // true for the reserved size code and for halves/words not on their natural boundary
  function automatic logic illegal(input logic [1:0] sz, input logic [1:0] lo);
    return (sz == 2'b11) | ((sz == SZ_H) & lo[0]) | ((sz == SZ_W) & (lo != 2'b00));
  endfunction
endpackage

// File: rtl/dmem_align.sv
// dmem_align: store lane enables/replicated data and load lane extract with sign/zero extension
module dmem_align
  import dmem_pkg::*;
(
  input  logic [1:0]       size_i,
  input  logic             uns_i,
  input  logic [1:0]       lo_i,
  input  logic [31:0]      wdata_i,
  input  logic [31:0]      rword_i,
  output logic [LANES-1:0] be_o,
  output logic [31:0]      wlane_o,
  output logic [31:0]      rext_o
);
  logic [LANE_W-1:0] rb;
  logic [15:0]       rh;
  // store data is replicated onto every lane so the byte enables alone pick the target lanes
  always_comb begin
    be_o    = size_i == SZ_B ? LANES'(1) << lo_i : size_i == SZ_H ? (lo_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wlane_o = size_i == SZ_B ? {LANES{wdata_i[7:0]}} : size_i == SZ_H ? {2{wdata_i[15:0]}} : wdata_i;
  end
  // load picks the addressed lane(s) and extends to a full word
  always_comb begin
    rb     = rword_i[{lo_i, 3'b000} +: LANE_W];
    rh     = lo_i[1] ? rword_i[31:16] : rword_i[15:0];
    rext_o = size_i == SZ_B ? {{24{rb[7] & ~uns_i}}, rb} : size_i == SZ_H ? {{16{rh[15] & ~uns_i}}, rh} : rword_i;
  end
endmodule

// File: rtl/dmem_hs.sv
// dmem_hs: word-organised data memory with req/ready/done handshake and programmable wait states
module dmem_hs
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 7,
  parameter int WAIT_CYC   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err
);
  localparam int WORDS = 2 ** DEPTH_LOG2;
  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q, uns_q, err_q;
  logic [1:0]              size_q;
  logic [DEPTH_LOG2+1:0]   addr_q;
  logic [31:0]             wdata_q, rdata_q, rdata_d;
  logic [31:0]             mem [WORDS];
  logic                    idle, c_we, c_uns, c_bad;
  logic [1:0]              c_size;
  logic [DEPTH_LOG2+1:0]   c_addr;
  logic [31:0]             c_wdata, wlane, rext;
  logic [LANES-1:0]        be;
  logic [DEPTH_LOG2-1:0]   idx;
  logic                    unused_addr;
  assign unused_addr = ^addr[31:DEPTH_LOG2+2];
  assign idle    = state_q == S_IDLE;
  assign c_we    = idle ? we : we_q;
  assign c_uns   = idle ? uns : uns_q;
  assign c_size  = idle ? size : size_q;
  assign c_addr  = idle ? addr[DEPTH_LOG2+1:0] : addr_q;
  assign c_wdata = idle ? wdata : wdata_q;
  assign c_bad   = illegal(c_size, c_addr[1:0]);
  assign idx     = c_addr[DEPTH_LOG2+1:2];
  assign ready   = idle;
  assign done    = state_q == S_RESP;
  assign err     = done & err_q;
  assign rdata   = rdata_q;
  dmem_align u_align (
    .size_i  (c_size),
    .uns_i   (c_uns),
    .lo_i    (c_addr[1:0]),
    .wdata_i (c_wdata),
    .rword_i (mem[idx]),
    .be_o    (be),
    .wlane_o (wlane),
    .rext_o  (rext)
  );
  // next state, wait counter and the load result captured on entry to RESP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (req) begin
        state_d = (WAIT_CYC > 0 && !c_bad) ? S_WAIT : S_RESP;
        cnt_d   = (WAIT_CYC > 0 && !c_bad) ? 4'(WAIT_CYC - 1) : 4'd0;
      end
      S_WAIT: begin
        state_d = cnt_q == 4'd0 ? S_RESP : S_WAIT;
        cnt_d   = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    rdata_d = (state_d == S_RESP && state_q != S_RESP && !c_we && !c_bad) ? rext : 32'd0;
  end
  // control state and the request fields held steady for the whole access
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      if (idle && req) begin
        we_q    <= we;
        uns_q   <= uns;
        err_q   <= c_bad;
        size_q  <= size;
        addr_q  <= addr[DEPTH_LOG2+1:0];
        wdata_q <= wdata;
      end
    end
  end
  // store commits on the edge that leaves RESP; an aborted access never reaches this
  always_ff @(posedge clk) begin
    if (state_q == S_RESP && we_q && !err_q)
      for (int i = 0; i < LANES; i++)
        if (be[i]) mem[idx][i*LANE_W +: LANE_W] <= wlane[i*LANE_W +: LANE_W];
  end
endmodule

// File: tb/tb_dmem_hs.sv
// tb_dmem_hs: randomized and directed checks of dmem_hs against a byte-array reference model
module tb_dmem_hs;
  localparam int W0 = 2;
  localparam int W1 = 0;
  logic        clk = 0, reset = 1, req = 0, req1 = 0, we = 0, uns = 0;
  logic [1:0]  size = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic        rdy0, dn0, er0, rdy1, dn1, er1;
  logic [31:0] rd0, rd1, r;
  logic [7:0]  mem_m [2][512];
  int          n_chk = 0, n_err = 0;
  dmem_hs #(.DEPTH_LOG2(7), .WAIT_CYC(W0)) dut0 (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .uns(uns), .addr(addr),
    .wdata(wdata), .ready(rdy0), .rdata(rd0), .done(dn0), .err(er0));
  dmem_hs #(.DEPTH_LOG2(7), .WAIT_CYC(W1)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .we(we), .size(size), .uns(uns), .addr(addr),
    .wdata(wdata), .ready(rdy1), .rdata(rd1), .done(dn1), .err(er1));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic int nbytes(input logic [1:0] sz);
    return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
  endfunction
  function automatic logic [31:0] mload(input int s, input logic [1:0] sz, input logic u, input logic [31:0] a);
    int n, b;
    logic [63:0] v;
    n = nbytes(sz);
    b = int'(a % 512);
    v = '0;
    for (int i = 0; i < n; i++) v = v | (64'(mem_m[s][(b + i) % 512]) << (8 * i));
    if (!u && v[8*n-1]) v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction
  task automatic mstore(input int s, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int b;
    b = int'(a % 512);
    for (int i = 0; i < nbytes(sz); i++) mem_m[s][(b + i) % 512] = 8'(d >> (8 * i));
  endtask
  task automatic acc(input bit s, input logic w, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] d, input bit spam, output logic [31:0] ro);
    int lat;
    bit got, bad;
    logic [31:0] exp;
    bad = sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    exp = (!w && !bad) ? mload(s, sz, u, a) : 32'd0;
    @(posedge clk); #1;
    we = w; size = sz; uns = u; addr = a; wdata = d;
    if (s) req1 = 1; else req = 1;
    check("ready_idle", s ? rdy1 : rdy0, 1);
    lat = 0;
    got = 0;
    while (!got && lat < 40) begin
      @(posedge clk); lat++; #1;
      we = 1'($urandom); size = 2'($urandom); uns = 1'($urandom); addr = $urandom; wdata = $urandom;
      if (!spam) begin req = 0; req1 = 0; end
      @(negedge clk);
      got = s ? dn1 : dn0;
    end
    req = 0; req1 = 0;
    ro = s ? rd1 : rd0;
    check("done", 32'(got), 1);
    check("latency", lat, bad ? 1 : (s ? W1 : W0) + 1);
    check("err", s ? er1 : er0, 32'(bad));
    check("rdata", ro, exp);
    check("ready_at_done", s ? rdy1 : rdy0, 0);
    if (w && !bad) mstore(s, sz, a, d);
    if (spam) repeat (3) begin
      @(negedge clk);
      check("single_done", s ? dn1 : dn0, 0);
    end
  endtask
  initial begin
    logic [1:0] sz;
    logic [31:0] a, msk;
    #2;
    check("rst_ready", rdy0, 1);
    check("rst_done", dn0, 0);
    check("rst_err", er0, 0);
    check("rst_rdata", rd0, 0);
    repeat (3) @(negedge clk);
    reset = 0;
    for (int i = 0; i < 128; i++) acc(0, 1, 2'd2, 0, 32'(i * 4), 32'd0, 0, r);
    acc(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, r);
    acc(0, 0, 2'd2, 0, 32'h10, 0, 0, r);
    check("lw_deadbeef", r, 32'hDEADBEEF);
    acc(0, 1, 2'd2, 0, 32'h10, 32'h0, 0, r);
    acc(0, 1, 2'd0, 0, 32'h13, 32'h80, 0, r);
    acc(0, 0, 2'd0, 0, 32'h13, 0, 0, r);
    check("lb_sext", r, 32'hFFFFFF80);
    acc(0, 0, 2'd0, 1, 32'h13, 0, 0, r);
    check("lbu", r, 32'h00000080);
    acc(0, 0, 2'd2, 0, 32'h10, 0, 0, r);
    check("lw_after_sb", r, 32'h80000000);
    acc(0, 1, 2'd2, 0, 32'h20, 32'h5555AAAA, 0, r);
    acc(0, 1, 2'd1, 0, 32'h22, 32'h9999_1234, 0, r);
    acc(0, 0, 2'd1, 1, 32'h22, 0, 0, r);
    check("lhu", r, 32'h00001234);
    acc(0, 0, 2'd2, 0, 32'h20, 0, 0, r);
    check("lw_after_sh", r, 32'h1234AAAA);
    acc(0, 0, 2'd2, 0, 32'h11, 0, 0, r);
    acc(0, 1, 2'd1, 0, 32'h03, 32'hFFFF, 0, r);
    acc(0, 1, 2'd3, 0, 32'h20, 32'hFFFFFFFF, 0, r);
    acc(0, 1, 2'd2, 0, 32'h21, 32'hFFFFFFFF, 0, r);
    acc(0, 0, 2'd2, 0, 32'h20, 0, 0, r);
    check("unchanged_after_err", r, 32'h1234AAAA);
    acc(0, 1, 2'd2, 0, 32'h200, 32'hCAFEF00D, 1, r);
    acc(0, 0, 2'd2, 0, 32'h000, 0, 1, r);
    check("wrap", r, 32'hCAFEF00D);
    acc(0, 1, 2'd2, 0, 32'h40, 32'h11112222, 0, r);
    @(posedge clk); #1;
    we = 1; size = 2'd2; uns = 0; addr = 32'h40; wdata = 32'hFFFFFFFF; req = 1;
    @(posedge clk); #1;
    req = 0;
    @(posedge clk); #1;
    reset = 1;
    #1;
    check("abort_ready", rdy0, 1);
    check("abort_done", dn0, 0);
    check("abort_rdata", rd0, 0);
    @(negedge clk);
    reset = 0;
    repeat (4) begin
      @(negedge clk);
      check("abort_no_done", dn0, 0);
    end
    acc(0, 0, 2'd2, 0, 32'h40, 0, 0, r);
    check("abort_old_data", r, 32'h11112222);
    acc(1, 1, 2'd2, 0, 32'h8, 32'h0BADF00D, 0, r);
    acc(1, 0, 2'd1, 0, 32'hA, 0, 0, r);
    check("w0_lh", r, 32'h00000BAD);
    acc(1, 0, 2'd2, 0, 32'h9, 0, 0, r);
    for (int i = 0; i < 300; i++) begin
      sz = 2'($urandom);
      a = $urandom;
      msk = sz == 2'd2 ? 32'hFFFFFFFC : sz == 2'd1 ? 32'hFFFFFFFE : 32'hFFFFFFFF;
      if ($urandom_range(3) != 0) a = a & msk;
      acc(0, 1'($urandom), sz, 1'($urandom), a, $urandom, $urandom_range(7) == 0, r);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
